// File: rtl/fir_decimator.sv
// fir_decimator: decimating 4-tap FIR filter with one time-shared MAC.
//
// Accepts one signed sample per i_en cycle into a G_TAPS-deep delay line.
// Every G_DECIM accepted samples the post-shift delay line is copied into
// a working buffer. The single MAC then walks through the taps, one tap
// per clock. A trigger that arrives while the MAC is still running is
// dropped and flagged.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_en       sample strobe; i_sample is accepted on every edge with i_en=1
//   i_sample   signed input sample (G_I_W bits)
//   o_result   signed filter output (G_O_W bits), held between updates
//   o_valid    one-cycle pulse marking a new o_result
//   o_busy     high while the MAC is running
//   o_overrun  one-cycle pulse when a trigger is dropped because the MAC is busy
module fir_decimator #(
  parameter int G_TAPS    = 4,
  parameter int G_DECIM   = 2,
  parameter int G_I_W     = 9,
  parameter int G_T_W     = 8,
  parameter int G_O_W     = 23,
  parameter int G_COEFF_A = -1,
  parameter int G_COEFF_B = -22,
  parameter int G_COEFF_C = 13,
  parameter int G_COEFF_D = -44
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [G_I_W-1:0] i_sample,
  output logic [G_O_W-1:0] o_result,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int P_W  = G_I_W + G_T_W;
  localparam int K_W  = (G_TAPS > 1) ? $clog2(G_TAPS) : 1;
  localparam int PH_W = (G_DECIM > 1) ? $clog2(G_DECIM) : 1;

  // c[0] multiplies the newest sample, c[3] the oldest.
  localparam logic signed [G_T_W-1:0] COEFF [4] = '{
    G_T_W'(G_COEFF_A), G_T_W'(G_COEFF_B), G_T_W'(G_COEFF_C), G_T_W'(G_COEFF_D)
  };

  typedef enum logic {
    S_IDLE,
    S_MAC
  } state_t;

  state_t                   state;
  logic signed [G_I_W-1:0]  d [G_TAPS];
  logic signed [G_I_W-1:0]  w [G_TAPS];
  logic signed [G_O_W-1:0]  acc;
  logic        [K_W-1:0]    k;
  logic        [PH_W-1:0]   phase;

  logic                     trigger;
  logic signed [G_I_W-1:0]  w_sel;
  logic signed [G_T_W-1:0]  c_sel;
  logic signed [P_W-1:0]    product;
  logic signed [G_O_W-1:0]  prod_ext;
  logic signed [G_O_W-1:0]  acc_next;

  // Decimation phase counts accepted samples, not clock cycles.
  assign trigger = i_en && (phase == PH_W'(G_DECIM - 1));

  always_comb begin
    w_sel    = w[k];
    c_sel    = COEFF[k];
    // Both operands widened to the full product width so the multiply
    // is done at P_W bits with correct sign handling.
    product  = $signed({{G_T_W{w_sel[G_I_W-1]}}, w_sel})
             * $signed({{G_I_W{c_sel[G_T_W-1]}}, c_sel});
    prod_ext = {{(G_O_W - P_W){product[P_W-1]}}, product};
    acc_next = acc + prod_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned j = 0; j < G_TAPS; j++) begin
        d[j] <= '0;
        w[j] <= '0;
      end
      acc       <= '0;
      k         <= '0;
      phase     <= '0;
      state     <= S_IDLE;
      o_result  <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;

      // The delay line and phase keep running whatever the MAC is doing.
      if (i_en) begin
        d[0] <= $signed(i_sample);
        for (int unsigned j = 1; j < G_TAPS; j++) begin
          d[j] <= d[j-1];
        end
        phase <= trigger ? '0 : phase + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (trigger) begin
            // Snapshot the post-shift line: the incoming sample is tap 0.
            w[0] <= $signed(i_sample);
            for (int unsigned j = 1; j < G_TAPS; j++) begin
              w[j] <= d[j-1];
            end
            acc    <= '0;
            k      <= '0;
            state  <= S_MAC;
            o_busy <= 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          // The running sum reads only w[], so a dropped trigger cannot
          // disturb it even though d[] keeps shifting.
          if (trigger) begin
            o_overrun <= 1'b1;
          end
          if (k == K_W'(G_TAPS - 1)) begin
            o_result <= acc_next;
            o_valid  <= 1'b1;
            o_busy   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Testbench for fir_decimator. Two instances share the same stimulus:
// dut2 uses the default decimation ratio of 2, and dut1 uses a ratio of 1.
// A reference model at the sample/transaction level predicts every output
// of both instances on every cycle. Directed table rows and hand-written
// sequences additionally pin the known results.
module tb_fir_decimator;

  localparam int TAPS = 4;
  int coef [TAPS] = '{-1, -22, 13, -44};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic [8:0]  smp;
  logic [22:0] res0, res1;
  logic        v0, v1, b0, b1, o0, o1;

  fir_decimator #(.G_DECIM(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sample(smp),
    .o_result(res0), .o_valid(v0), .o_busy(b0), .o_overrun(o0)
  );

  fir_decimator #(.G_DECIM(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sample(smp),
    .o_result(res1), .o_valid(v1), .o_busy(b1), .o_overrun(o1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state per instance: history of accepted samples,
  // sample count within the decimation group, and edges left until the
  // pending result appears.
  int decim  [2] = '{2, 1};
  int m_hist [2][TAPS];
  int m_phase[2];
  int m_left [2];
  int m_pend [2];
  int m_res  [2];
  int m_v    [2];
  int m_o    [2];
  int m_b    [2];

  task automatic model_edge(input int i);
    bit trig;
    bit was_busy;
    int y;
    if (rst) begin
      for (int j = 0; j < TAPS; j++) m_hist[i][j] = 0;
      m_phase[i] = 0; m_left[i] = 0; m_pend[i] = 0;
      m_res[i] = 0; m_v[i] = 0; m_o[i] = 0; m_b[i] = 0;
      return;
    end
    m_v[i] = 0;
    m_o[i] = 0;
    trig     = en && (m_phase[i] == decim[i] - 1);
    was_busy = m_left[i] > 0;
    if (was_busy) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_res[i] = m_pend[i];
        m_v[i]   = 1;
      end
    end
    if (en) begin
      for (int j = TAPS - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = int'($signed(smp));
      m_phase[i] = (m_phase[i] + 1) % decim[i];
    end
    if (trig) begin
      if (was_busy) begin
        m_o[i] = 1;
      end else begin
        y = 0;
        for (int j = 0; j < TAPS; j++) y += coef[j] * m_hist[i][j];
        m_pend[i] = y;
        m_left[i] = TAPS;
      end
    end
    m_b[i] = (m_left[i] > 0) ? 1 : 0;
  endtask

  int seen0, last0;
  int cnt_v1, cnt_o1, cnt_o0;

  // One clock: the model follows the edge, outputs are compared on the
  // falling edge, and the caller may change inputs afterwards.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check("d2_result",  int'($signed(res0)), m_res[0]);
    check("d2_valid",   int'(v0), m_v[0]);
    check("d2_busy",    int'(b0), m_b[0]);
    check("d2_overrun", int'(o0), m_o[0]);
    check("d1_result",  int'($signed(res1)), m_res[1]);
    check("d1_valid",   int'(v1), m_v[1]);
    check("d1_busy",    int'(b1), m_b[1]);
    check("d1_overrun", int'(o1), m_o[1]);
    if (v0) begin
      seen0 = 1;
      last0 = int'($signed(res0));
    end
    if (o0) cnt_o0++;
    if (v1) cnt_v1++;
    if (o1) cnt_o1++;
  endtask

  task automatic sample_then_idle(input int s, input int gap);
    smp = 9'(s);
    en  = 1'b1;
    step();
    en  = 1'b0;
    repeat (gap) step();
  endtask

  // chk: 0 = model only, 1 = expect an o_valid with exp, 2 = expect no o_valid
  typedef struct {
    int sample;
    int gap;
    int chk;
    int exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int ov_before;

    // Impulse, spacing 6 cycles
    tbl.push_back('{1, 5, 2, 0});
    tbl.push_back('{0, 5, 1, -22});
    tbl.push_back('{0, 5, 2, 0});
    tbl.push_back('{0, 5, 1, -44});
    tbl.push_back('{0, 5, 2, 0});
    tbl.push_back('{0, 5, 1, 0});
    // Step
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1, 5, (i % 2 == 0) ? 2 : 1, (i == 1) ? -23 : -54});
    // Negative full scale, then positive full scale
    tbl.push_back('{-256, 5, 2, 0});
    tbl.push_back('{-256, 5, 0, 0});
    tbl.push_back('{-256, 5, 2, 0});
    tbl.push_back('{-256, 5, 1, 13824});
    tbl.push_back('{255, 5, 2, 0});
    tbl.push_back('{255, 5, 0, 0});
    tbl.push_back('{255, 5, 2, 0});
    tbl.push_back('{255, 5, 1, -13770});

    rst = 1'b1; en = 1'b0; smp = '0;
    seen0 = 0; last0 = 0; cnt_v1 = 0; cnt_o1 = 0; cnt_o0 = 0;
    step();
    step();
    check("reset_result", int'($signed(res0)), 0);
    check("reset_busy", int'(b0), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      seen0 = 0;
      sample_then_idle(tbl[i].sample, tbl[i].gap);
      if (tbl[i].chk == 1) begin
        check("tbl_valid_seen", seen0, 1);
        check("tbl_result", last0, tbl[i].exp);
      end else if (tbl[i].chk == 2) begin
        check("tbl_no_valid", seen0, 0);
      end
    end
    check("tbl_no_overrun", cnt_o0, 0);

    // Reset two cycles after a trigger aborts the computation
    sample_then_idle(5, 0);
    sample_then_idle(7, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_result", int'($signed(res0)), 0);
    check("midrst_valid", int'(v0), 0);
    check("midrst_busy", int'(b0), 0);
    check("midrst_overrun", int'(o0), 0);
    seen0 = 0;
    repeat (6) step();
    check("midrst_no_valid", seen0, 0);
    seen0 = 0;
    sample_then_idle(1, 5);
    sample_then_idle(0, 5);
    check("post_rst_seen", seen0, 1);
    check("post_rst_impulse", last0, -22);

    // Back-to-back samples force overruns at ratio 2
    ov_before = cnt_o0;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      smp = 9'($urandom_range(0, 511));
      step();
    end
    en = 1'b0;
    repeat (6) step();
    check("burst_overrun_seen", int'(cnt_o0 > ov_before), 1);

    // Irregular gaps
    for (int i = 0; i < 60; i++)
      sample_then_idle(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 10)));
    repeat (6) step();

    // Ratio 1: spacing 5 cycles is lossless
    cnt_v1 = 0; cnt_o1 = 0;
    for (int i = 0; i < 8; i++) sample_then_idle(int'($urandom_range(0, 511)) - 256, 4);
    repeat (6) step();
    check("d1_sp5_valids", cnt_v1, 8);
    check("d1_sp5_overruns", cnt_o1, 0);

    // Ratio 1: spacing 4 cycles drops every other trigger
    cnt_v1 = 0; cnt_o1 = 0;
    for (int i = 0; i < 8; i++) sample_then_idle(int'($urandom_range(0, 511)) - 256, 3);
    repeat (6) step();
    check("d1_sp4_valids", cnt_v1, 4);
    check("d1_sp4_overruns", cnt_o1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
